// File: rtl/rx_sequencer.sv
// rx_sequencer: bit-timing controller for the UART receive path.
//
// Synchronizes the raw serial line and detects the start bit. It then times
// mid-bit sampling and pulses shift_enable once per data bit into an external
// LSB-first serial-to-parallel shift register. Finally it checks the stop bit
// and issues load_buffer plus the receive status flags.
//
// Optional feature macro: RX_SEQ_PARITY_EN. When it is defined, an even-parity
// bit follows the data bits and is checked. When it is undefined, the frame
// has no parity bit and parity_error is tied low.
//
// Parameters:
//   BIT_PERIOD    clocks per serial bit (>= 4)
//   NUM_DATA_BITS data bits per frame
// Ports:
//   clk            clock
//   n_rst          asynchronous active-low reset
//   serial_in      raw asynchronous receive line, idle high
//   data_read      consumer acknowledges the buffered byte (one-cycle pulse)
//   rx_bit         synchronized serial line, feeds the shift register input
//   shift_enable   one-cycle pulse per data bit, at mid-bit
//   load_buffer    one-cycle pulse: receive buffer captures the shift register
//   data_ready     buffer holds an unread byte
//   framing_error  last frame had a zero stop bit
//   overrun_error  a byte was loaded over an unread one
//   parity_error   parity mismatch (0 when parity is not compiled in)
module rx_sequencer #(
    parameter int BIT_PERIOD    = 10,
    parameter int NUM_DATA_BITS = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic serial_in,
    input  logic data_read,
    output logic rx_bit,
    output logic shift_enable,
    output logic load_buffer,
    output logic data_ready,
    output logic framing_error,
    output logic overrun_error,
    output logic parity_error
);

    localparam int CNT_W  = $clog2(BIT_PERIOD);
    localparam int BCNT_W = $clog2(NUM_DATA_BITS + 1);

    localparam logic [CNT_W-1:0]  HALF_LAST    = CNT_W'(BIT_PERIOD / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST     = CNT_W'(BIT_PERIOD - 1);
    localparam logic [BCNT_W-1:0] BIT_CNT_LAST = BCNT_W'(NUM_DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_CHK,
        DATA_WAIT,
        PARITY_WAIT,
        STOP_WAIT,
        LOAD
    } state_t;

    state_t              state, state_next;
    logic                sync_1;
    logic                rx_prev;
    logic                start_edge;
    logic [CNT_W-1:0]    cnt;
    logic                cnt_clr;
    logic [BCNT_W-1:0]   bit_cnt;
    logic                start_ok;
    logic                stop_bad;
`ifdef RX_SEQ_PARITY_EN
    logic                par_chk;
`endif

    // NOTE: the synchronizer and edge flops reset to 1 (idle line level), so
    // leaving reset can never look like a falling start edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_1  <= 1'b1;
            rx_bit  <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync_1  <= serial_in;
            rx_bit  <= sync_1;
            rx_prev <= rx_bit;
        end
    end

    assign start_edge = rx_prev & ~rx_bit;

    // NOTE: every register is updated with non-blocking assignments so that
    // all flops sample pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_clr ? '0 : cnt + CNT_W'(1);
            if (state != DATA_WAIT)
                bit_cnt <= '0;
            else if (shift_enable)
                bit_cnt <= (bit_cnt == BIT_CNT_LAST) ? '0 : bit_cnt + BCNT_W'(1);
        end
    end

    // Every state change coincides with cnt_clr, so the cycle counter always
    // starts a new wait from zero.
    always_comb begin
        // NOTE: defaults first keep this block free of inferred latches.
        state_next   = state;
        cnt_clr      = 1'b0;
        shift_enable = 1'b0;
        load_buffer  = 1'b0;
        start_ok     = 1'b0;
        stop_bad     = 1'b0;
`ifdef RX_SEQ_PARITY_EN
        par_chk      = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (start_edge)
                    state_next = START_CHK;
            end
            START_CHK: begin
                if (cnt == HALF_LAST) begin
                    cnt_clr = 1'b1;
                    if (!rx_bit) begin
                        start_ok   = 1'b1;
                        state_next = DATA_WAIT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA_WAIT: begin
                if (cnt == BIT_LAST) begin
                    cnt_clr      = 1'b1;
                    shift_enable = 1'b1;
                    if (bit_cnt == BIT_CNT_LAST) begin
`ifdef RX_SEQ_PARITY_EN
                        state_next = PARITY_WAIT;
`else
                        state_next = STOP_WAIT;
`endif
                    end
                end
            end
`ifdef RX_SEQ_PARITY_EN
            PARITY_WAIT: begin
                if (cnt == BIT_LAST) begin
                    cnt_clr    = 1'b1;
                    par_chk    = 1'b1;
                    state_next = STOP_WAIT;
                end
            end
`endif
            STOP_WAIT: begin
                if (cnt == BIT_LAST) begin
                    cnt_clr = 1'b1;
                    if (rx_bit) begin
                        state_next = LOAD;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            LOAD: begin
                cnt_clr     = 1'b1;
                load_buffer = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                cnt_clr    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    // Status flags. A data_read coincident with LOAD wins over the overrun
    // check: the consumer took the old byte, so the new one is not an overrun.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_ready    <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            if (start_ok)
                framing_error <= 1'b0;
            else if (stop_bad)
                framing_error <= 1'b1;

            if (load_buffer)
                data_ready <= 1'b1;
            else if (data_read)
                data_ready <= 1'b0;

            if (data_read)
                overrun_error <= 1'b0;
            else if (load_buffer && data_ready)
                overrun_error <= 1'b1;
        end
    end

`ifdef RX_SEQ_PARITY_EN
    logic par_acc;
    logic parity_q;

    // Running XOR of the sampled data bits; restarted on entry to START_CHK.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            par_acc  <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            if (state_next == START_CHK && state != START_CHK)
                par_acc <= 1'b0;
            else if (shift_enable)
                par_acc <= par_acc ^ rx_bit;

            if (start_ok)
                parity_q <= 1'b0;
            else if (par_chk)
                parity_q <= par_acc ^ rx_bit;
        end
    end

    assign parity_error = parity_q;
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_rx_sequencer.sv
// tb_rx_sequencer: directed testbench for rx_sequencer (BIT_PERIOD=10,
// NUM_DATA_BITS=8, parity not compiled in). A monitor records shift/load
// activity and models the LSB-first shift register fed by rx_bit.
module tb_rx_sequencer;

    logic clk;
    logic n_rst;
    logic serial_in;
    logic data_read;
    logic rx_bit;
    logic shift_enable;
    logic load_buffer;
    logic data_ready;
    logic framing_error;
    logic overrun_error;
    logic parity_error;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Monitor state (written only by the monitor process).
    int         shift_n = 0;
    int         shift_cyc [0:255];
    int         load_n  = 0;
    int         load_cyc = 0;
    int         both_n  = 0;
    logic [7:0] shreg   = '0;
    logic [7:0] cap     = '0;

    rx_sequencer #(.BIT_PERIOD(10), .NUM_DATA_BITS(8)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in),
        .data_read     (data_read),
        .rx_bit        (rx_bit),
        .shift_enable  (shift_enable),
        .load_buffer   (load_buffer),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .parity_error  (parity_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (shift_enable) begin
            if (shift_n < 256)
                shift_cyc[shift_n] = cyc;
            shift_n = shift_n + 1;
            shreg   = {rx_bit, shreg[7:1]};
        end
        if (load_buffer) begin
            load_n   = load_n + 1;
            load_cyc = cyc;
            cap      = shreg;
        end
        if (shift_enable && load_buffer)
            both_n = both_n + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one full frame (start, 8 data bits LSB first, stop). Returns the
    // start_edge cycle E. Optionally pulses data_read in the LOAD cycle (E+96).
    task automatic send_frame(input logic [7:0] data, input logic stop,
                              input logic rd_at_load, output int e);
        logic [9:0] bits;
        bits = {stop, data, 1'b0};
        e = cyc + 2;
        for (int b = 0; b < 10; b++) begin
            serial_in = bits[b];
            for (int j = 0; j < 10; j++) begin
                data_read = (rd_at_load && b == 9 && j == 8);
                tick();
            end
        end
        data_read = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int e, input int s_base,
                               input int l_base, input logic [7:0] data);
        chk({tag, "_shifts"}, shift_n - s_base, 8);
        for (int k = 0; k < 8; k++)
            chk({tag, "_shift_cyc"}, shift_cyc[s_base + k], e + 15 + 10 * k);
        chk({tag, "_loads"}, load_n - l_base, 1);
        chk({tag, "_load_cyc"}, load_cyc, e + 96);
        chk({tag, "_data"}, {24'd0, cap}, {24'd0, data});
    endtask

    initial begin
        int e;
        int s_base;
        int l_base;

        n_rst     = 1'b0;
        serial_in = 1'b1;
        data_read = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_rx_bit", rx_bit, 1);
        chk("rst_shift", shift_enable, 0);
        chk("rst_load", load_buffer, 0);
        chk("rst_ready", data_ready, 0);
        chk("rst_ferr", framing_error, 0);
        chk("rst_oerr", overrun_error, 0);
        chk("rst_perr", parity_error, 0);

        n_rst = 1'b1;
        repeat (3) tick();

        // Clean frame 0xA5
        s_base = shift_n; l_base = load_n;
        send_frame(8'hA5, 1'b1, 1'b0, e);
        check_frame("clean", e, s_base, l_base, 8'hA5);
        chk("clean_ready", data_ready, 1);
        chk("clean_ferr", framing_error, 0);
        chk("clean_oerr", overrun_error, 0);

        // data_read clears data_ready one cycle later
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        chk("read_clears_ready", data_ready, 0);

        // False start: 3-cycle low glitch
        s_base = shift_n; l_base = load_n;
        serial_in = 1'b0;
        repeat (3) tick();
        serial_in = 1'b1;
        repeat (20) tick();
        chk("glitch_shifts", shift_n - s_base, 0);
        chk("glitch_loads", load_n - l_base, 0);
        chk("glitch_ready", data_ready, 0);
        chk("glitch_ferr", framing_error, 0);

        // Framing error: 0x3C with stop bit 0
        s_base = shift_n; l_base = load_n;
        send_frame(8'h3C, 1'b0, 1'b0, e);
        serial_in = 1'b1;
        repeat (5) tick();
        chk("ferr_shifts", shift_n - s_base, 8);
        chk("ferr_loads", load_n - l_base, 0);
        chk("ferr_flag", framing_error, 1);
        chk("ferr_ready", data_ready, 0);

        // Good frame clears framing_error (first of a back-to-back pair)
        s_base = shift_n; l_base = load_n;
        send_frame(8'hC3, 1'b1, 1'b0, e);
        check_frame("recover", e, s_base, l_base, 8'hC3);
        chk("recover_ferr", framing_error, 0);
        chk("recover_ready", data_ready, 1);
        chk("recover_oerr", overrun_error, 0);

        // Overrun: second frame back-to-back without data_read
        s_base = shift_n; l_base = load_n;
        send_frame(8'h81, 1'b1, 1'b0, e);
        check_frame("overrun", e, s_base, l_base, 8'h81);
        chk("overrun_flag", overrun_error, 1);
        chk("overrun_ready", data_ready, 1);
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        chk("overrun_read_ready", data_ready, 0);
        chk("overrun_read_oerr", overrun_error, 0);

        // Simultaneous read and load
        s_base = shift_n; l_base = load_n;
        send_frame(8'h0F, 1'b1, 1'b0, e);
        check_frame("pre_sim", e, s_base, l_base, 8'h0F);
        s_base = shift_n; l_base = load_n;
        send_frame(8'hF0, 1'b1, 1'b1, e);
        check_frame("sim", e, s_base, l_base, 8'hF0);
        chk("sim_ready", data_ready, 1);
        chk("sim_oerr", overrun_error, 0);
        chk("never_both", both_n, 0);

        // Reset mid-frame after 4 shifts (data_ready is still 1 here)
        s_base = shift_n; l_base = load_n;
        serial_in = 1'b0;
        repeat (10) tick();
        for (int b = 0; b < 4; b++) begin
            serial_in = b[0];
            repeat (10) tick();
        end
        chk("mid_shifts", shift_n - s_base, 4);
        serial_in = 1'b1;
        n_rst = 1'b0;
        #1;
        chk("mid_rst_ready", data_ready, 0);
        chk("mid_rst_shift", shift_enable, 0);
        chk("mid_rst_load", load_buffer, 0);
        chk("mid_rst_rx_bit", rx_bit, 1);
        chk("mid_rst_ferr", framing_error, 0);
        chk("mid_rst_oerr", overrun_error, 0);
        repeat (3) tick();
        n_rst = 1'b1;
        repeat (3) tick();
        chk("mid_no_partial_load", load_n - l_base, 0);

        s_base = shift_n; l_base = load_n;
        send_frame(8'h5A, 1'b1, 1'b0, e);
        check_frame("post_rst", e, s_base, l_base, 8'h5A);
        chk("post_rst_ready", data_ready, 1);
        chk("post_rst_oerr", overrun_error, 0);
        chk("post_rst_perr", parity_error, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_sequencer.md
# rx_sequencer

Bit-timing controller for the UART receive path: detects a start bit on the raw serial line, times mid-bit sampling, and drives `shift_enable` of the companion flexible serial-to-parallel shift register. It then checks the stop bit and issues the buffer-load and status signals.

- The shift register is built with `NUM_BITS = NUM_DATA_BITS` and `SHIFT_MSB = 0`, so data arrives LSB first.
- The block sits between the pad-level serial input and the receive data buffer.

## Interface
Parameters:
- `BIT_PERIOD`, default 10: clocks per serial bit. Must be 4 or more.
- `NUM_DATA_BITS`, default 8: number of data bits per frame.

Ports:
- `clk` (in, 1): clock.
- `n_rst` (in, 1): reset, asynchronous, active-low.
- `serial_in` (in, 1): raw asynchronous receive line, idle high.
- `data_read` (in, 1): consumer acknowledges the buffered byte; one-cycle pulse.
- `rx_bit` (out, 1): synchronized serial line; drives the shift register's `serial_in`.
- `shift_enable` (out, 1): one-cycle pulse per data bit, to the shift register.
- `load_buffer` (out, 1): one-cycle pulse; the receive buffer captures the shift register output.
- `data_ready` (out, 1): the buffer holds an unread byte.
- `framing_error` (out, 1): the last frame had stop bit = 0.
- `overrun_error` (out, 1): a new byte was loaded over an unread one.
- `parity_error` (out, 1): parity mismatch. Tied 0 when parity is not compiled in.

## Operation
- **Input synchronizer:** two flops, reset value 1. `rx_bit` is the second flop.
- **Edge detector:** a previous-value flop on `rx_bit`, reset value 1. `start_edge = prev & ~rx_bit`.
- **Cycle counter:** width `$clog2(BIT_PERIOD)`. It clears on every state change and counts up while waiting.
- **Bit counter:** width `$clog2(NUM_DATA_BITS+1)`.

FSM states and transitions:
- **IDLE** → START_CHK on `start_edge`.
- **START_CHK:** waits `BIT_PERIOD/2` cycles (integer division).
  - Samples `rx_bit` on the final cycle.
  - 0 → DATA_WAIT, and `framing_error` clears.
  - 1 → IDLE (false start; no outputs change).
- **DATA_WAIT:** waits `BIT_PERIOD` cycles. On the final cycle `shift_enable` = 1 and the bit counter increments.
  - After `NUM_DATA_BITS` shifts → STOP_WAIT (or PARITY_WAIT when parity is compiled in).
  - Otherwise it stays in DATA_WAIT.
- **STOP_WAIT:** waits `BIT_PERIOD` cycles, then samples `rx_bit`.
  - 1 → LOAD.
  - 0 → `framing_error` is set, no load occurs, → IDLE.
- **LOAD:** one cycle.
  - `load_buffer` = 1 and `data_ready` is set.
  - If `data_ready` was already 1 and `data_read` is low this cycle, `overrun_error` is set.
  - → IDLE.

Status rules:
- `data_read` clears `data_ready` and `overrun_error`.
- If `data_read` and LOAD occur in the same cycle, `data_ready` stays 1 and no overrun is flagged.
- `shift_enable` and `load_buffer` are never high in the same cycle.
- Edges on the line outside IDLE are ignored.

## Timing
- Reset values:
  - State = IDLE and all counters = 0.
  - `rx_bit` = 1.
  - `shift_enable`, `load_buffer`, `data_ready`, `framing_error`, `overrun_error` and `parity_error` = 0.
- Synchronizer latency: a `serial_in` change appears on `rx_bit` 2 cycles later. `start_edge` is high in that same cycle.
- Let E be the `start_edge` cycle.
  - Start sample is at cycle E + `BIT_PERIOD/2`.
  - Data bit k (k = 0..`NUM_DATA_BITS`-1) has its `shift_enable` pulse at E + `BIT_PERIOD/2` + (k+1)·`BIT_PERIOD`.
  - Stop sample is at E + `BIT_PERIOD/2` + (`NUM_DATA_BITS`+1)·`BIT_PERIOD`, plus one more `BIT_PERIOD` when parity is compiled in.
  - `load_buffer` is asserted 1 cycle after the stop sample.
- `data_ready` rises the cycle after `load_buffer`. It falls the cycle after a `data_read` that is not coincident with LOAD.
- IDLE accepts a new `start_edge` the cycle after LOAD or a framing error, so back-to-back frames with one stop bit are received.
- Reset asserted mid-frame returns to IDLE immediately and clears all status outputs. A partial byte is never loaded.

## Configuration
- **`RX_SEQ_PARITY_EN` defined:**
  - Adds state PARITY_WAIT between the last data bit and STOP_WAIT. It waits `BIT_PERIOD` cycles and samples the parity bit.
  - A running XOR of the data bits sampled at each `shift_enable` is kept; it clears when START_CHK is entered.
  - Even parity: `parity_error` is set if the XOR of data and parity bit = 1.
  - `parity_error` clears on START_CHK success. Load still occurs on a parity error if the stop bit is valid.
- **Undefined:** no parity bit in the frame and `parity_error` = 0 constant.

## Test plan
All scenarios use `BIT_PERIOD` = 10 and `NUM_DATA_BITS` = 8.
- **Clean frame:** send 0xA5 (start 0, LSB first, stop 1).
  - Exactly 8 `shift_enable` pulses, 10 cycles apart, the first at E+15.
  - `load_buffer` at E+96; `data_ready` = 1; the shift register holds 0xA5.
- **False start:** a 3-cycle low glitch while idle → FSM returns to IDLE at E+5. Zero `shift_enable`, no status change.
- **Framing error:** frame 0x3C with stop bit 0 → `framing_error` = 1, no `load_buffer`, `data_ready` unchanged. The next good frame clears `framing_error`.
- **Overrun:** two back-to-back frames without `data_read` → second LOAD sets `overrun_error`. A `data_read` pulse clears both `data_ready` and `overrun_error`.
- **Simultaneous read and load:** `data_read` in the LOAD cycle → `data_ready` stays 1 and `overrun_error` stays 0.
- **Reset mid-frame:** `n_rst` low after 4 `shift_enable` pulses → all outputs reset immediately. A following full frame of 0x5A is received correctly.
